// File: rtl/pad_mux_pkg.sv
// Shared types and width helpers for the pad multiplexing controller.
// Widths are derived from the default bank shape; instances override through parameters.
package pad_mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } state_e;

    localparam int PINS_DEF   = 8;
    localparam int FUNCS_DEF  = 4;
    localparam int SETTLE_DEF = 4;
    localparam int SYNC_DEF   = 2;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int PIN_W  = width_of(PINS_DEF);
    localparam int FUNC_W = width_of(FUNCS_DEF);
    localparam int CNT_W  = width_of(SETTLE_DEF + 1);

endpackage

// File: rtl/pad_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous pad input.
module pad_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] ff_q;
    logic [STAGES-1:0] ff_d;

    // Shift the pad value one stage deeper each cycle.
    always_comb begin
        ff_d = {ff_q[STAGES-2:0], din};
    end

    // Synchroniser flops, cleared by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ff_q <= {STAGES{1'b0}};
        end else begin
            ff_q <= ff_d;
        end
    end

    assign dout = ff_q[STAGES-1];

endmodule

// File: rtl/pad_mux_ctrl.sv
// Pin-mux controller: per-pin owner select with a tristate-settle-apply hand-over,
// registered pad outputs and synchronised, owner-gated pad inputs.
module pad_mux_ctrl
    import pad_mux_pkg::*;
#(
    parameter int PINS        = PINS_DEF,
    parameter int FUNCS       = FUNCS_DEF,
    parameter int SETTLE      = SETTLE_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [width_of(PINS)-1:0]       cfg_pin,
    input  logic [width_of(FUNCS)-1:0]      cfg_func,
    output logic                            cfg_err,
    output logic                            busy,
    output logic [PINS*width_of(FUNCS)-1:0] sel,
    input  logic [FUNCS*PINS-1:0]           func_out,
    input  logic [FUNCS*PINS-1:0]           func_oe,
    output logic [FUNCS*PINS-1:0]           func_in,
    output logic [PINS-1:0]                 pad_din,
    output logic [PINS-1:0]                 pad_oen,
    input  logic [PINS-1:0]                 pad_dout
);

    localparam int PW = width_of(PINS);
    localparam int FW = width_of(FUNCS);
    localparam int CW = width_of(SETTLE + 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           pin_q, pin_d;
    logic [FW-1:0]           func_q, func_d;
    logic [PINS-1:0][FW-1:0] sel_q, sel_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [PINS-1:0]         din_q, din_d;
    logic [PINS-1:0]         oen_q, oen_d;
    logic [PINS-1:0]         drain_cur_s, drain_nxt_s;
    logic [PINS-1:0]         mux_dout_s, mux_en_s;
    logic [PINS-1:0]         sync_s;
    logic                    idx_ok_s;

    assign idx_ok_s = (int'(cfg_pin) < PINS) && (int'(cfg_func) < FUNCS);

    // Next-state logic for the ownership hand-over sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pin_d   = pin_q;
        func_d  = func_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (!idx_ok_s) begin
                        err_d = 1'b1;
                    end else if (cfg_func != sel_q[cfg_pin]) begin
                        state_d = DRAIN;
                        cnt_d   = {CW{1'b0}};
                        pin_d   = cfg_pin;
                        func_d  = cfg_func;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    state_d       = APPLY;
                    sel_d[pin_q]  = func_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            APPLY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // Drain masks: current one gates inputs, next one gates the registered pad outputs.
    always_comb begin
        for (int i = 0; i < PINS; i++) begin
            drain_cur_s[i] = (state_q != IDLE) && (pin_q == PW'(i));
            drain_nxt_s[i] = (state_d != IDLE) && (pin_d == PW'(i));
        end
    end

    // Per-pin AND-OR output mux from the owning function, forced tristate while draining.
    always_comb begin
        mux_dout_s = {PINS{1'b0}};
        mux_en_s   = {PINS{1'b0}};
        for (int i = 0; i < PINS; i++) begin
            for (int f = 0; f < FUNCS; f++) begin
                mux_dout_s[i] = mux_dout_s[i] | ((sel_q[i] == FW'(f)) & func_out[f*PINS+i]);
                mux_en_s[i]   = mux_en_s[i]   | ((sel_q[i] == FW'(f)) & func_oe[f*PINS+i]);
            end
        end
        din_d = mux_dout_s & ~drain_nxt_s;
        oen_d = ~mux_en_s | drain_nxt_s;
    end

    // Route each synchronised pad input only to its current owner.
    always_comb begin
        func_in = {(FUNCS*PINS){1'b0}};
        for (int i = 0; i < PINS; i++) begin
            for (int f = 0; f < FUNCS; f++) begin
                func_in[f*PINS+i] = (sel_q[i] == FW'(f)) & ~drain_cur_s[i] & sync_s[i];
            end
        end
    end

    // FSM state, settle counter, select register file and handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            pin_q   <= {PW{1'b0}};
            func_q  <= {FW{1'b0}};
            sel_q   <= {(PINS*FW){1'b0}};
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pin_q   <= pin_d;
            func_q  <= func_d;
            sel_q   <= sel_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Registered pad drive; reset leaves every pad tristate.
    always_ff @(posedge clk) begin
        if (!reset) begin
            din_q <= {PINS{1'b0}};
            oen_q <= {PINS{1'b1}};
        end else begin
            din_q <= din_d;
            oen_q <= oen_d;
        end
    end

    for (genvar g = 0; g < PINS; g++) begin : g_sync
        pad_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .din   (pad_dout[g]),
            .dout  (sync_s[g])
        );
    end

    assign cfg_ready = ready_q;
    assign busy      = busy_q;
    assign cfg_err   = err_q;
    assign sel       = sel_q;
    assign pad_din   = din_q;
    assign pad_oen   = oen_q;

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Scoreboard bench for pad_mux_ctrl: random traffic against a schedule-based reference model.
module tb_pad_mux_ctrl;

    localparam int P  = 6;
    localparam int F  = 3;
    localparam int S  = 4;
    localparam int SS = 2;
    localparam int PW = 3;
    localparam int FW = 2;
    localparam int FP = F * P;

    localparam int K_ERR  = 0;
    localparam int K_NOOP = 1;
    localparam int K_SW   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [PW-1:0] cfg_pin = 3'd0;
    logic [FW-1:0] cfg_func = 2'd0;
    logic          cfg_err;
    logic          busy;
    logic [P*FW-1:0] sel;
    logic [FP-1:0] func_out = '0;
    logic [FP-1:0] func_oe = '0;
    logic [FP-1:0] func_in;
    logic [P-1:0]  pad_din;
    logic [P-1:0]  pad_oen;
    logic [P-1:0]  pad_dout = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit force3 = 1'b0;

    typedef struct {
        int kind;
        int pin;
        int func;
        int e;
    } exp_t;
    exp_t sb[$];

    int msel[P];
    int msel_prev[P];
    bit sw_active = 1'b0;
    int sw_e = 0;
    int sw_pin = 0;
    int sw_func = 0;
    logic [P-1:0]  hist[16];
    logic [FP-1:0] fo_prev;
    logic [FP-1:0] foe_prev;
    logic rst_prev = 1'b1;
    logic ready_prev = 1'b1;
    bit   started = 1'b0;

    pad_mux_ctrl #(
        .PINS        (P),
        .FUNCS       (F),
        .SETTLE      (S),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_pin   (cfg_pin),
        .cfg_func  (cfg_func),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .sel       (sel),
        .func_out  (func_out),
        .func_oe   (func_oe),
        .func_in   (func_in),
        .pad_din   (pad_din),
        .pad_oen   (pad_oen),
        .pad_dout  (pad_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [P*FW-1:0] pack_sel();
        logic [P*FW-1:0] v;
        v = '0;
        for (int i = 0; i < P; i++) v[i*FW +: FW] = FW'(msel[i]);
        return v;
    endfunction

    // Reference: each accepted switch drains its pin for edges E..E+S, new owner visible from E+S.
    task automatic monitor_step(input int c);
        logic [P-1:0]  exp_din;
        logic [P-1:0]  exp_oen;
        logic [FP-1:0] exp_in;
        logic [P-1:0]  sync_v;
        logic          exp_err;
        bit            dr;
        if (!rst_prev) begin
            started   = 1'b1;
            sw_active = 1'b0;
            sb.delete();
            for (int i = 0; i < P; i++) msel[i] = 0;
            for (int k = 1; k <= SS; k++) hist[(c - k) & 15] = '0;
            chk("rst_sel", sel, 0);
            chk("rst_ready", cfg_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_err", cfg_err, 0);
            chk("rst_oen", pad_oen, {P{1'b1}});
            chk("rst_din", pad_din, 0);
            chk("rst_func_in", func_in, 0);
        end else if (started) begin
            if (sw_active && c == sw_e + S) msel[sw_pin] = sw_func;
            dr = sw_active && c >= sw_e && c <= sw_e + S;
            exp_err = 1'b0;
            if (sb.size() > 0) begin
                case (sb[0].kind)
                    K_ERR: begin
                        if (c == sb[0].e) begin
                            exp_err = 1'b1;
                            chk("err_pulse", cfg_err, 1);
                            chk("err_sel", sel, pack_sel());
                            void'(sb.pop_front());
                        end
                    end
                    K_NOOP: begin
                        if (c == sb[0].e) begin
                            chk("noop_busy", busy, 0);
                            chk("noop_ready", cfg_ready, 1);
                            chk("noop_sel", sel[sb[0].pin*FW +: FW], sb[0].func);
                            void'(sb.pop_front());
                        end
                    end
                    K_SW: begin
                        if (c == sb[0].e + S + 1) begin
                            chk("sw_ready_rise", {ready_prev, cfg_ready}, 2'b01);
                            chk("sw_sel", sel[sb[0].pin*FW +: FW], sb[0].func);
                            void'(sb.pop_front());
                        end
                    end
                    default: ;
                endcase
            end
            chk("ready", cfg_ready, !dr);
            chk("busy", busy, dr);
            chk("err_line", cfg_err, exp_err);
            chk("sel", sel, pack_sel());
            sync_v = hist[(c - SS) & 15];
            exp_in = '0;
            for (int i = 0; i < P; i++) begin
                if (dr && sw_pin == i) begin
                    exp_din[i] = 1'b0;
                    exp_oen[i] = 1'b1;
                end else begin
                    exp_din[i] = fo_prev[msel_prev[i]*P + i];
                    exp_oen[i] = ~foe_prev[msel_prev[i]*P + i];
                    exp_in[msel[i]*P + i] = sync_v[i];
                end
            end
            chk("pad_din", pad_din, exp_din);
            chk("pad_oen", pad_oen, exp_oen);
            chk("func_in", func_in, exp_in);
        end
        hist[c & 15] = pad_dout;
        fo_prev      = func_out;
        foe_prev     = func_oe;
        rst_prev     = reset;
        ready_prev   = cfg_ready;
        for (int i = 0; i < P; i++) msel_prev[i] = msel[i];
    endtask

    initial begin
        for (int k = 0; k < 16; k++) hist[k] = '0;
        for (int i = 0; i < P; i++) begin
            msel[i] = 0;
            msel_prev[i] = 0;
        end
        fo_prev  = '0;
        foe_prev = '0;
        forever begin
            @(negedge clk);
            monitor_step(cyc);
        end
    end

    // Random peripheral and pad traffic; pin 3 / func 2 can be pinned to drive a 1.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            func_out = FP'($urandom);
            func_oe  = FP'($urandom);
            pad_dout = P'($urandom);
            if (force3) begin
                func_out[2*P+3] = 1'b1;
                func_oe[2*P+3]  = 1'b1;
            end
        end
    end

    task automatic do_req(input int pin, input int func);
        bit   done;
        exp_t ent;
        done      = 1'b0;
        cfg_valid = 1'b1;
        cfg_pin   = PW'(pin);
        cfg_func  = FW'(func);
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (cfg_ready && reset) begin
                ent.pin  = pin;
                ent.func = func;
                ent.e    = cyc + 1;
                if (pin >= P || func >= F) begin
                    ent.kind = K_ERR;
                end else if (msel[pin] == func) begin
                    ent.kind = K_NOOP;
                end else begin
                    ent.kind  = K_SW;
                    sw_pin    = pin;
                    sw_func   = func;
                    sw_e      = cyc + 1;
                    sw_active = 1'b1;
                end
                sb.push_back(ent);
                done = 1'b1;
            end
        end
        chk("req_accepted", done, 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (cfg_ready && sb.size() == 0) ok = 1'b1;
        end
        chk("idle_reached", ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        force3 = 1'b1;
        do_req(3, 2);
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        force3 = 1'b0;
        do_req(7, 1);
        do_req(2, 3);
        do_req(3, 2);
        do_req(1, 1);
        do_req(4, 2);
        wait_idle();
        for (int k = 0; k < 40; k++) begin
            do_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        // Abort a hand-over two cycles into the settle window.
        do_req(5, (msel[5] + 1) % F);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_req(5, 1);
        do_req(0, 2);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
